// File: rtl/integrator_pkg.sv
// -----------------------------------------------------------------------------
// integrator_pkg
// Shared definitions for the multi-mode integrator:
//   - mode_e     : run-time integration rule encodings
//   - acc_width  : accumulator width derivation (output width plus guard bits)
// -----------------------------------------------------------------------------
package integrator_pkg;

  typedef enum logic [1:0] {
    MODE_RECT = 2'd0,  // y[n] = y[n-1] + c0*x[n]
    MODE_TRAP = 2'd1,  // y[n] = y[n-1] + c0*x[n] + c1*x[n-1]
    MODE_SIMP = 2'd2,  // y[n] = y[n-2] + c0*x[n] + c1*x[n-1] + c2*x[n-2]
    MODE_HOLD = 2'd3   // y[n] = y[n-1], history of y untouched
  } mode_e;

  function automatic int acc_width(input int out_w, input int guard);
    return out_w + guard;
  endfunction

endpackage

// File: rtl/integrator_sat.sv
// -----------------------------------------------------------------------------
// integrator_sat
// Combinational signed saturator from ACC_W bits down to OUT_W bits.
//   acc_i  : signed accumulator value
//   sat_o  : acc_i clipped to [-2^(OUT_W-1), 2^(OUT_W-1)-1]
//   clip_o : high when acc_i was outside the output range
// -----------------------------------------------------------------------------
module integrator_sat #(
  parameter int ACC_W = 26,
  parameter int OUT_W = 22
) (
  input  logic signed [ACC_W-1:0] acc_i,
  output logic signed [OUT_W-1:0] sat_o,
  output logic                    clip_o
);

  localparam int TOP_W = ACC_W - OUT_W + 1;

  // The value fits exactly when every bit from the output sign bit upward is a
  // copy of the accumulator sign bit.
  logic in_range;
  assign in_range = (acc_i[ACC_W-1:OUT_W-1] == {TOP_W{acc_i[ACC_W-1]}});

  // NOTE: every output of a combinational block gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    clip_o = 1'b0;
    sat_o  = acc_i[OUT_W-1:0];
    if (!in_range) begin
      clip_o = 1'b1;
      sat_o  = acc_i[ACC_W-1] ? {1'b1, {(OUT_W-1){1'b0}}}
                              : {1'b0, {(OUT_W-1){1'b1}}};
    end
  end

endmodule

// File: rtl/integrator_multimode.sv
// -----------------------------------------------------------------------------
// integrator_multimode
// Two-stage discrete-time integrator for a signed fixed-point sample stream,
// rule selected per sample (rectangular, trapezoidal, Simpson, hold).
//   clk, reset        : clock, synchronous active-high reset (beats clk_enable)
//   clk_enable        : global enable, every register holds when low
//   clear             : synchronous state clear, qualified by clk_enable
//   mode              : integration rule, captured with each accepted sample
//   coef0/coef1/coef2 : unsigned weights for x[n], x[n-1], x[n-2]
//   in_valid, In      : sample strobe and signed sample
//   out_valid, Out    : one-cycle result strobe and saturated result
//   sat               : sticky clipping flag, cleared by reset or clear
// Latency: a sample presented in cycle k yields out_valid/Out in cycle k+2
// (counting enabled cycles only).
// -----------------------------------------------------------------------------
module integrator_multimode
  import integrator_pkg::*;
#(
  parameter int DATA_W    = 22,
  parameter int DATA_FRAC = 10,
  parameter int COEF_W    = 12,
  parameter int COEF_FRAC = 10,
  parameter int OUT_W     = 22,
  parameter int GUARD     = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clk_enable,
  input  logic                     clear,
  input  logic [1:0]               mode,
  input  logic [COEF_W-1:0]        coef0,
  input  logic [COEF_W-1:0]        coef1,
  input  logic [COEF_W-1:0]        coef2,
  input  logic                     in_valid,
  input  logic signed [DATA_W-1:0] In,
  output logic                     out_valid,
  output logic signed [OUT_W-1:0]  Out,
  output logic                     sat
);

  localparam int ACC_W  = acc_width(OUT_W, GUARD);
  localparam int PROD_W = DATA_W + COEF_W + 1;

  // Out carries DATA_FRAC+COEF_FRAC fractional bits; the format needs at least
  // one integer (sign) bit left over.
  if (DATA_FRAC + COEF_FRAC > OUT_W - 1) begin : g_bad_format
    $error("integrator_multimode: output fractional bits exceed OUT_W-1");
  end

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic                     s1_valid_q, s1_valid_d;
  logic signed [ACC_W-1:0]  p_q, p_d;
  mode_e                    mode_q, mode_d;
  logic signed [DATA_W-1:0] x1_q, x1_d, x2_q, x2_d;
  logic                     out_valid_q, out_valid_d;
  logic signed [OUT_W-1:0]  y1_q, y1_d, y2_q, y2_d;
  logic                     sat_q, sat_d;

  // ---------------------------------------------------------------------------
  // Stage 1 datapath: full-precision products, sum carried in ACC_W bits.
  // Coefficients are unsigned, so a zero is prepended before the signed multiply.
  // ---------------------------------------------------------------------------
  logic signed [PROD_W-1:0] prod0, prod1, prod2;
  logic signed [ACC_W-1:0]  p_sum;

  assign prod0 = PROD_W'($signed({1'b0, coef0})) * PROD_W'(In);
  assign prod1 = PROD_W'($signed({1'b0, coef1})) * PROD_W'(x1_q);
  assign prod2 = PROD_W'($signed({1'b0, coef2})) * PROD_W'(x2_q);

  always_comb begin
    p_sum = ACC_W'(prod0);
    case (mode_e'(mode))
      MODE_TRAP: p_sum = ACC_W'(prod0) + ACC_W'(prod1);
      MODE_SIMP: p_sum = ACC_W'(prod0) + ACC_W'(prod1) + ACC_W'(prod2);
      default:   p_sum = ACC_W'(prod0);
    endcase
  end

  // ---------------------------------------------------------------------------
  // Stage 2 datapath: Simpson spans two samples, so it integrates onto y[n-2].
  // ---------------------------------------------------------------------------
  logic signed [ACC_W-1:0] acc;
  logic signed [OUT_W-1:0] sat_val;
  logic                    clip;

  assign acc = p_q + ((mode_q == MODE_SIMP) ? ACC_W'(y2_q) : ACC_W'(y1_q));

  integrator_sat #(
    .ACC_W (ACC_W),
    .OUT_W (OUT_W)
  ) u_sat (
    .acc_i  (acc),
    .sat_o  (sat_val),
    .clip_o (clip)
  );

  // ---------------------------------------------------------------------------
  // Next-state logic. clear behaves like reset but only on enabled cycles, and
  // it wins over a same-cycle sample, which is dropped.
  // ---------------------------------------------------------------------------
  always_comb begin
    s1_valid_d  = s1_valid_q;
    p_d         = p_q;
    mode_d      = mode_q;
    x1_d        = x1_q;
    x2_d        = x2_q;
    out_valid_d = out_valid_q;
    y1_d        = y1_q;
    y2_d        = y2_q;
    sat_d       = sat_q;

    if (clk_enable) begin
      if (clear) begin
        s1_valid_d  = 1'b0;
        p_d         = '0;
        mode_d      = MODE_RECT;
        x1_d        = '0;
        x2_d        = '0;
        out_valid_d = 1'b0;
        y1_d        = '0;
        y2_d        = '0;
        sat_d       = 1'b0;
      end else begin
        s1_valid_d  = in_valid;
        out_valid_d = s1_valid_q;
        if (in_valid) begin
          p_d    = p_sum;
          mode_d = mode_e'(mode);
          x1_d   = In;
          x2_d   = x1_q;
        end
        // Hold samples still pulse out_valid but leave the y history alone;
        // Out is y1, so it repeats the previous result.
        if (s1_valid_q && (mode_q != MODE_HOLD)) begin
          y1_d  = sat_val;
          y2_d  = y1_q;
          sat_d = sat_q | clip;
        end
      end
    end
  end

  // NOTE: sequential state is written with non-blocking assignments only, so
  // every register samples the pre-edge value of every other register.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid_q  <= 1'b0;
      p_q         <= '0;
      mode_q      <= MODE_RECT;
      x1_q        <= '0;
      x2_q        <= '0;
      out_valid_q <= 1'b0;
      y1_q        <= '0;
      y2_q        <= '0;
      sat_q       <= 1'b0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      p_q         <= p_d;
      mode_q      <= mode_d;
      x1_q        <= x1_d;
      x2_q        <= x2_d;
      out_valid_q <= out_valid_d;
      y1_q        <= y1_d;
      y2_q        <= y2_d;
      sat_q       <= sat_d;
    end
  end

  assign out_valid = out_valid_q;
  assign Out       = y1_q;
  assign sat       = sat_q;

endmodule

// File: tb/tb_integrator_multimode.sv
// -----------------------------------------------------------------------------
// tb_integrator_multimode
// Scoreboard bench: the driver computes each accepted sample's result from the
// integration rules with plain integer arithmetic and queues it together with
// the enabled-cycle count at which it must appear. A negedge monitor compares
// out_valid, Out and sat every cycle.
// -----------------------------------------------------------------------------
module tb_integrator_multimode;

  localparam int OUT_MAX = 2097151;
  localparam int OUT_MIN = -2097152;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic               clk_enable = 1'b0;
  logic               clear = 1'b0;
  logic [1:0]         mode = 2'd0;
  logic [11:0]        coef0 = '0, coef1 = '0, coef2 = '0;
  logic               in_valid = 1'b0;
  logic signed [21:0] in_s = '0;
  logic               out_valid;
  logic signed [21:0] out_s;
  logic               sat_s;

  integrator_multimode dut (
    .clk        (clk),
    .reset      (reset),
    .clk_enable (clk_enable),
    .clear      (clear),
    .mode       (mode),
    .coef0      (coef0),
    .coef1      (coef1),
    .coef2      (coef2),
    .in_valid   (in_valid),
    .In         (in_s),
    .out_valid  (out_valid),
    .Out        (out_s),
    .sat        (sat_s)
  );

  always #5 clk = ~clk;

  typedef struct {
    int due;
    int out;
    bit sat;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_fail = 0;

  // Counts edges at which the DUT state may change (enabled or reset).
  int   ecount = 0;
  bit   upd = 1'b0;
  bit   was_clr = 1'b0;

  task automatic check(input string name, input logic signed [63:0] act,
                       input logic signed [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at t=%0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  always @(posedge clk) begin
    upd     <= reset | clk_enable;
    was_clr <= reset | (clear & clk_enable);
    if (reset | clk_enable) ecount <= ecount + 1;
  end

  // ---------------------------------------------------------------------------
  // Monitor
  // ---------------------------------------------------------------------------
  bit exp_ov = 1'b0;
  int exp_out = 0;
  bit exp_sat = 1'b0;

  always @(negedge clk) begin
    exp_t e;
    if (was_clr) begin
      exp_ov  = 1'b0;
      exp_out = 0;
      exp_sat = 1'b0;
    end else if (upd) begin
      exp_ov = 1'b0;
      while (sb.size() > 0 && sb[0].due < ecount) begin
        check("late_result", ecount, sb[0].due);
        void'(sb.pop_front());
      end
      if (sb.size() > 0 && sb[0].due == ecount) begin
        e       = sb.pop_front();
        exp_ov  = 1'b1;
        exp_out = e.out;
        exp_sat = e.sat;
      end
    end
    check("out_valid", out_valid, exp_ov);
    check("Out", out_s, exp_out);
    check("sat", sat_s, exp_sat);
  end

  // ---------------------------------------------------------------------------
  // Reference model: integration rules on the sequence of accepted samples.
  // ---------------------------------------------------------------------------
  int mx1 = 0, mx2 = 0, my1 = 0, my2 = 0;
  bit msat = 1'b0;

  task automatic model_reset();
    mx1 = 0; mx2 = 0; my1 = 0; my2 = 0; msat = 1'b0;
    // Results still in flight are cancelled; one due at the current count has
    // already appeared and is left for the monitor.
    while (sb.size() > 0 && sb[$].due > ecount) void'(sb.pop_back());
  endtask

  task automatic model_accept(input int x);
    longint c0, c1, c2, acc;
    int     o;
    bit     clip;
    exp_t   e;
    c0 = coef0; c1 = coef1; c2 = coef2;
    clip = 1'b0;
    case (mode)
      2'd0:    acc = c0 * x + my1;
      2'd1:    acc = c0 * x + c1 * mx1 + my1;
      2'd2:    acc = c0 * x + c1 * mx1 + c2 * mx2 + my2;
      default: acc = my1;
    endcase
    if (acc > OUT_MAX) begin
      o = OUT_MAX; clip = 1'b1;
    end else if (acc < OUT_MIN) begin
      o = OUT_MIN; clip = 1'b1;
    end else begin
      o = int'(acc);
    end
    mx2 = mx1;
    mx1 = x;
    if (mode != 2'd3) begin
      my2  = my1;
      my1  = o;
      msat = msat | clip;
    end
    e.due = ecount + 2;
    e.out = o;
    e.sat = msat;
    sb.push_back(e);
  endtask

  // One clock of stimulus: inputs are set #1 after a rising edge.
  task automatic cyc(input bit iv, input int x, input bit clr = 1'b0,
                     input bit en = 1'b1);
    in_valid   = iv;
    in_s       = 22'(x);
    clear      = clr;
    clk_enable = en;
    if (reset || (en && clr)) model_reset();
    else if (en && iv)        model_accept(x);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(1'b0, 0);
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    reset = 1'b1;
    repeat (2) cyc(1'b0, 0);
    reset = 1'b0;
    idle(1);

    // Latency, single rectangular sample.
    mode = 2'd0; coef0 = 12'd1024;
    cyc(1'b1, 256);
    idle(4);

    // Rectangular run into saturation, sticky flag, then clear.
    cyc(1'b0, 0, 1'b1);
    repeat (9) cyc(1'b1, 256);
    idle(3);
    cyc(1'b0, 0, 1'b1);

    // Trapezoid, back-to-back then with 3-cycle gaps.
    mode = 2'd1; coef0 = 12'd512; coef1 = 12'd512;
    repeat (4) cyc(1'b1, 256);
    idle(3);
    cyc(1'b0, 0, 1'b1);
    repeat (4) begin
      cyc(1'b1, 256);
      idle(3);
    end
    cyc(1'b0, 0, 1'b1);

    // Simpson impulse response.
    mode = 2'd2; coef0 = 12'd341; coef1 = 12'd1365; coef2 = 12'd341;
    cyc(1'b1, 1024);
    repeat (4) cyc(1'b1, 0);
    idle(3);

    // Clear mid-stream with a same-cycle sample.
    cyc(1'b1, 500);
    cyc(1'b1, -300);
    cyc(1'b1, 777, 1'b1);
    cyc(1'b1, 100);
    cyc(1'b1, 100);
    idle(3);

    // Clear ignored while disabled; reset acts while disabled.
    cyc(1'b1, 400);
    cyc(1'b1, 400);
    cyc(1'b1, 123, 1'b1, 1'b0);
    reset = 1'b1;
    cyc(1'b1, 999, 1'b0, 1'b0);
    reset = 1'b0;
    cyc(1'b1, 100);
    idle(3);

    // Enable dropped for 5 cycles mid-pipeline.
    mode = 2'd1;
    cyc(1'b1, 300);
    cyc(1'b1, 300);
    repeat (5) cyc(1'b1, 555, 1'b0, 1'b0);
    cyc(1'b1, 300);
    idle(4);

    // Hold sample between rectangular and trapezoid samples.
    cyc(1'b0, 0, 1'b1);
    mode = 2'd0;
    cyc(1'b1, 1000);
    mode = 2'd3;
    cyc(1'b1, 2000);
    mode = 2'd1;
    cyc(1'b1, 10);
    idle(3);

    // Randomized traffic; sample magnitude keeps stage-1 sums inside the
    // accumulator so only output saturation applies.
    repeat (600) begin
      mode  = 2'($urandom_range(0, 3));
      coef0 = 12'($urandom_range(0, 4095));
      coef1 = 12'($urandom_range(0, 4095));
      coef2 = 12'($urandom_range(0, 4095));
      reset = ($urandom_range(0, 149) == 0);
      cyc($urandom_range(0, 3) != 0, int'($urandom_range(0, 4095)) - 2048,
          $urandom_range(0, 39) == 0, $urandom_range(0, 9) != 0);
      reset = 1'b0;
    end

    idle(6);
    check("scoreboard_drained", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
